// File: rtl/stack_ctrl.sv
// stack_ctrl: stack sequencer in front of the data memory.
// Takes PUSH/POP/CALL/RET requests over a valid/ready handshake, owns the
// downward-growing stack pointer, and presents each access to the memory as
// one registered cycle (push or pop strobe plus sp/rez). Any overflow or
// underflow attempt parks the block in a sticky FAULT state until rst.
module stack_ctrl #(
    parameter logic [15:0] STACK_TOP   = 16'hFFFF,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [15:0] push_data,
    input  logic [15:0] ret_addr,
    output logic        req_ready,
    output logic [15:0] sp,
    output logic        push,
    output logic        pop,
    output logic [15:0] rez,
    output logic        done,
    output logic [1:0]  done_op,
    output logic        empty,
    output logic        full,
    output logic        fault
);

    // Op encoding: bit 0 clear = write-type (PUSH/CALL), set = read-type (POP/RET);
    // bit 1 selects the CALL/RET flavour.
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    // The slot just below the lowest legal one; reaching it means the stack is full.
    localparam logic [15:0] FULL_SP = STACK_LIMIT - 16'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_FAULT
    } state_t;

    state_t      state_reg;
    logic [15:0] sp_reg;
    logic [15:0] rez_reg;
    logic        push_reg;
    logic        pop_reg;
    logic        done_reg;
    logic [1:0]  done_op_reg;
    logic        fault_reg;

    logic        empty_w;
    logic        full_w;
    logic        accept_w;
    logic        is_write_w;

    // Bound checks come straight from the registered pointer so they are
    // valid in the same cycle a request is evaluated.
    assign empty_w    = (sp_reg == STACK_TOP);
    assign full_w     = (sp_reg == FULL_SP);
    assign accept_w   = req_valid && (state_reg == ST_IDLE);
    assign is_write_w = (req_op == OP_PUSH) || (req_op == OP_CALL);

    // Sequencer: accept in IDLE, spend exactly one cycle on the memory bus,
    // then return to IDLE; bound violations latch into FAULT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            sp_reg      <= STACK_TOP;
            rez_reg     <= 16'd0;
            push_reg    <= 1'b0;
            pop_reg     <= 1'b0;
            done_reg    <= 1'b0;
            done_op_reg <= 2'b00;
            fault_reg   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            push_reg <= 1'b0;
            pop_reg  <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept_w) begin
                        if (is_write_w) begin
                            if (full_w) begin
                                state_reg <= ST_FAULT;
                                fault_reg <= 1'b1;
                            end else begin
                                // sp already names the free slot; it moves after the write.
                                rez_reg     <= (req_op == OP_CALL) ? ret_addr : push_data;
                                done_op_reg <= req_op;
                                push_reg    <= 1'b1;
                                done_reg    <= 1'b1;
                                state_reg   <= ST_WR;
                            end
                        end else begin
                            if (empty_w) begin
                                state_reg <= ST_FAULT;
                                fault_reg <= 1'b1;
                            end else begin
                                // Step up first so the read cycle addresses the top entry.
                                sp_reg      <= sp_reg + 16'd1;
                                done_op_reg <= req_op;
                                pop_reg     <= 1'b1;
                                done_reg    <= 1'b1;
                                state_reg   <= ST_RD;
                            end
                        end
                    end
                end
                ST_WR: begin
                    sp_reg    <= sp_reg - 16'd1;
                    state_reg <= ST_IDLE;
                end
                ST_RD: begin
                    state_reg <= ST_IDLE;
                end
                ST_FAULT: begin
                    state_reg <= ST_FAULT;
                    fault_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_FAULT;
                    fault_reg <= 1'b1;
                end
            endcase
        end
    end

    // OP_POP/OP_RET are distinguished only through is_write_w; keep them named
    // for readers of the encoding.
    logic unused_ops_w;
    assign unused_ops_w = ^{OP_POP, OP_RET};

    assign req_ready = (state_reg == ST_IDLE);
    assign sp        = sp_reg;
    assign push      = push_reg;
    assign pop       = pop_reg;
    assign rez       = rez_reg;
    assign done      = done_reg;
    assign done_op   = done_op_reg;
    assign empty     = empty_w;
    assign full      = full_w;
    assign fault     = fault_reg;

endmodule
